pipelined_adder: RTL
====================

# pipelined_adder

Parametrised, pipelined add/subtract unit with valid/ready handshake. Splits an ADDER_WIDTH-bit operation into NUM_STAGES equal carry-propagating slices, one per register stage, so wide adds close timing at high clock rates. Produces sum, unsigned carry and signed overflow, and sits between the execute-stage operand muxes and any consumer that tolerates multi-cycle latency, such as address generation and the M-extension datapath.

## Interface
- ADDER_WIDTH, 32, operand/result width; must be a multiple of NUM_STAGES.
- NUM_STAGES, 4, pipeline depth and slice count; 1..ADDER_WIDTH.
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operands and mode valid this cycle.
- in_ready_o  output  1  unit accepts a transaction this cycle.
- adder_op1_i  input  ADDER_WIDTH  first operand.
- adder_op2_i  input  ADDER_WIDTH  second operand.
- sub_i  input  1  0 = op1+op2, 1 = op1-op2.
- out_valid_o  output  1  result fields valid.
- out_ready_i  input  1  consumer takes the result this cycle.
- sum_o  output  ADDER_WIDTH  result modulo 2^ADDER_WIDTH.
- carry_o  output  1  carry out of the MSB. For sub, 1 = no borrow (op1 >= op2 unsigned).
- overflow_o  output  1  signed two's-complement overflow.

## Operation
- Slice width SW = ADDER_WIDTH/NUM_STAGES. Stage s adds bits [s*SW +: SW] with the carry from stage s-1. Stage 0 carry-in = sub_i.
- Subtract: op2 is bit-inverted at entry, and carry-in is 1.
- Each stage register holds:
  - its valid bit,
  - the computed low result bits,
  - the running carry,
  - the not-yet-consumed upper operand bits (op2 already inverted),
  - the MSB signs of op1 and effective op2 for the overflow calculation.
- overflow_o = (op1[MSB] == op2eff[MSB]) && (sum[MSB] != op1[MSB]).
- Handshake: transfer in when in_valid_i && in_ready_o; transfer out when out_valid_o && out_ready_i.
- Global stall: advance = !out_valid_o || out_ready_i. in_ready_o = advance. When advance = 0, every stage register holds its value, including bubbles.
- When advance = 1, every stage shifts. Stage 0 loads in_valid_i and the new operands; if in_valid_i = 0, a bubble (valid = 0) enters.
- Data fields of invalid stages are don't-care. sum_o, carry_o and overflow_o are only meaningful while out_valid_o = 1.
- No reordering. Results leave in acceptance order.

## Timing
- Reset (rst_i high at an edge) clears all stage valid bits. After reset, out_valid_o = 0, sum_o = 0, carry_o = 0, overflow_o = 0, and in_ready_o = 1.
- Reset mid-operation discards every in-flight transaction. Inputs presented in a reset cycle are not accepted.
- Latency: a transaction accepted at the edge ending cycle c shows out_valid_o = 1 in cycle c+NUM_STAGES, absent stalls.
- NUM_STAGES = 1 gives one register, with the result in cycle c+1.
- Throughput is one transaction per cycle with out_ready_i held high.
- Outputs come straight from the last stage register. There is no combinational path from the adder_op*_i inputs to the outputs.
- in_ready_o depends combinationally on out_ready_i (one-gate path). This is accepted by design.
- Simultaneous in-transfer and out-transfer in the same cycle is legal and loses nothing.
- Stalled outputs remain stable until they are consumed.
- Wrap-around: the sum wraps modulo 2^ADDER_WIDTH, and the carry and overflow flags report it. There is no saturation.

## Structure
- Package adder_pkg holds:
  - typedef for the per-stage pipeline record (valid, partial sum, carry, residual operands, signs), parametrised through the module;
  - localparam rules: the SW derivation, and an elaboration-time assertion that ADDER_WIDTH % NUM_STAGES == 0.
- Sub-module adder_slice: combinational, SW-bit add with carry_i/carry_o. It is instantiated NUM_STAGES times through a generate loop.
- Pipeline registers and handshake logic live in pipelined_adder.

## Test plan
- Reset and latency (defaults): after reset, out_valid_o = 0. Apply 0x0000_0005 + 0x0000_0003 with out_ready_i = 1 → sum_o = 0x0000_0008, carry_o = 0, overflow_o = 0, exactly 4 cycles later.
- Carry across slices: 0xFFFF_FFFF + 0x0000_0001 → sum_o = 0x0000_0000, carry_o = 1, overflow_o = 0.
- Signed overflow and subtract:
  - 0x7FFF_FFFF + 1 → 0x8000_0000, overflow_o = 1.
  - 0x0000_0003 - 0x0000_0005 → 0xFFFF_FFFE, carry_o = 0, overflow_o = 0.
  - 0x8000_0000 - 1 → overflow_o = 1.
- Back-pressure: stream 8 back-to-back adds, then hold out_ready_i = 0 for 5 cycles mid-stream.
  - in_ready_o must be 0 while out_valid_o = 1 during the hold.
  - Outputs stay stable.
  - All 8 results arrive in order with none lost or duplicated.
- Reset mid-flight: accept 3 transactions, then assert rst_i for 1 cycle → out_valid_o stays 0 until new input is accepted after reset.
- Parameter sweep: random operands against a reference model for (ADDER_WIDTH, NUM_STAGES) = (32,1), (32,4), (64,8), (8,8), with random in_valid_i and out_ready_i.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared configuration helpers for the pipelined add/subtract unit.
//   DEF_ADDER_WIDTH / DEF_NUM_STAGES : default operand width and pipeline depth
//   slice_width()                    : bits handled by each pipeline stage
//   cfg_ok()                         : legality rule for a width/depth pair
// The per-stage record depends on the instance parameters, so its typedef is
// declared inside pipelined_adder using these helpers.
package adder_pkg;

  localparam int DEF_ADDER_WIDTH = 32;
  localparam int DEF_NUM_STAGES  = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Depth must be 1..width and divide the width evenly.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple slice: sum = a + b + carry_i.
//   a, b    : slice operand bits
//   carry_i : carry from the previous slice (or the subtract carry-in)
//   sum     : slice result bits
//   carry_o : carry into the next slice
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          carry_i,
  output logic [SW-1:0] sum,
  output logic          carry_o
);

  logic [SW:0] total;

  assign total   = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, carry_i};
  assign sum     = total[SW-1:0];
  assign carry_o = total[SW];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with a valid/ready handshake. The operation is
// split into NUM_STAGES equal slices, one slice per register stage, with the
// carry rippling forward through the pipeline registers.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : input handshake
//   adder_op1_i, adder_op2_i : operands
//   sub_i                    : 0 = op1 + op2, 1 = op1 - op2
//   out_valid_o / out_ready_i: output handshake
//   sum_o, carry_o           : result modulo 2^ADDER_WIDTH and MSB carry
//                              (for subtract, carry_o = 1 means no borrow)
//   overflow_o               : signed two's-complement overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
  parameter int NUM_STAGES  = DEF_NUM_STAGES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ADDER_WIDTH-1:0] adder_op1_i,
  input  logic [ADDER_WIDTH-1:0] adder_op2_i,
  input  logic                   sub_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ADDER_WIDTH-1:0] sum_o,
  output logic                   carry_o,
  output logic                   overflow_o
);

  localparam int SW = slice_width(ADDER_WIDTH, NUM_STAGES);

  if (!cfg_ok(ADDER_WIDTH, NUM_STAGES)) begin : g_cfg_check
    $error("pipelined_adder: ADDER_WIDTH must be a multiple of NUM_STAGES");
  end

  // One pipeline record. Operands are carried whole; each stage only reads
  // its own slice. op2 is stored already inverted for subtract.
  typedef struct packed {
    logic                   vld;
    logic [ADDER_WIDTH-1:0] sum;
    logic                   cy;
    logic [ADDER_WIDTH-1:0] op1;
    logic [ADDER_WIDTH-1:0] op2;
    logic                   sign1;
    logic                   sign2;
  } stage_t;

  stage_t stage_p [NUM_STAGES];
  stage_t nxt     [NUM_STAGES];
  stage_t entry;
  logic [ADDER_WIDTH-1:0] op2_eff;
  logic                   advance;

  // Entry: subtract is op1 + ~op2 + 1.
  assign op2_eff = sub_i ? ~adder_op2_i : adder_op2_i;

  always_comb begin
    entry.vld   = in_valid_i;
    entry.sum   = '0;
    entry.cy    = sub_i;
    entry.op1   = adder_op1_i;
    entry.op2   = op2_eff;
    entry.sign1 = adder_op1_i[ADDER_WIDTH-1];
    entry.sign2 = op2_eff[ADDER_WIDTH-1];
  end

  // Stage s computes slice s from the record held by stage s-1.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    stage_t          src;
    stage_t          rec;
    logic [SW-1:0]   slice_sum;
    logic            slice_cy;

    if (s == 0) begin : g_first
      assign src = entry;
    end else begin : g_next
      assign src = stage_p[s-1];
    end

    adder_slice #(
      .SW(SW)
    ) u_slice (
      .a      (src.op1[s*SW +: SW]),
      .b      (src.op2[s*SW +: SW]),
      .carry_i(src.cy),
      .sum    (slice_sum),
      .carry_o(slice_cy)
    );

    always_comb begin
      rec                 = src;
      rec.sum[s*SW +: SW] = slice_sum;
      rec.cy              = slice_cy;
    end

    assign nxt[s] = rec;
  end

  // Global stall: the whole pipe moves together, bubbles included.
  assign advance    = !stage_p[NUM_STAGES-1].vld || out_ready_i;
  assign in_ready_o = advance;

  // Pipeline registers; reset clears only the valid bits, and a reset
  // overriding stage 0's load keeps inputs of the reset cycle out.
  always_ff @(posedge clk_i) begin
    if (advance) begin
      for (int s = 0; s < NUM_STAGES; s++) stage_p[s] <= nxt[s];
    end
    if (rst_i) begin
      for (int s = 0; s < NUM_STAGES; s++) stage_p[s].vld <= 1'b0;
    end
  end

  // Outputs from the last register, forced to zero while it holds a bubble.
  assign out_valid_o = stage_p[NUM_STAGES-1].vld;
  assign sum_o       = stage_p[NUM_STAGES-1].vld ? stage_p[NUM_STAGES-1].sum : '0;
  assign carry_o     = stage_p[NUM_STAGES-1].vld & stage_p[NUM_STAGES-1].cy;
  assign overflow_o  = stage_p[NUM_STAGES-1].vld
                     & (stage_p[NUM_STAGES-1].sign1 == stage_p[NUM_STAGES-1].sign2)
                     & (stage_p[NUM_STAGES-1].sum[ADDER_WIDTH-1] != stage_p[NUM_STAGES-1].sign1);

endmodule
